// File: rtl/clk_div_cfg_arb_pkg.sv
// Shared types and default widths for the clock-divider configuration arbiter.
package clk_div_cfg_arb_pkg;

  localparam int DEF_NUM_REQ         = 2;
  localparam int DEF_DIV_VALUE_WIDTH = 32;
  localparam int DEF_TIMEOUT_WIDTH   = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    WAIT = 2'd2,
    ACK  = 2'd3
  } clk_div_cfg_state_e;

endpackage

// File: rtl/clk_div_cfg_arb_if.sv
// Load bus between the configuration arbiter (master) and the clock divider (slave).
interface clk_div_cfg_arb_if
  import clk_div_cfg_arb_pkg::*;
#(
  parameter int DIV_VALUE_WIDTH = DEF_DIV_VALUE_WIDTH
);
  // Handshake: a load transfers in a cycle where div_valid and div_ready are both 1;
  // div and clk_init hold while div_valid is 1; div_done is only meaningful after the transfer.
  logic [DIV_VALUE_WIDTH-1:0] div;
  logic                       clk_init;
  logic                       div_valid;
  logic                       div_ready;
  logic                       div_done;

  modport master (output div, output clk_init, output div_valid,
                  input  div_ready, input div_done);
  modport slave  (input  div, input clk_init, input div_valid,
                  output div_ready, output div_done);
endinterface

// File: rtl/clk_div_cfg_arb_rr_arb_ptr.sv
// Round-robin pick: lowest requesting index at or above ptr, wrapping.
module rr_arb_ptr #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx
);
  logic found;
  int   j;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      j = int'(ptr) + i;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!found && req[j]) begin
        found    = 1'b1;
        grant[j] = 1'b1;
        idx      = IDX_W'(j);
      end
    end
  end
endmodule

// File: rtl/dffr.sv
// Enabled D flip-flop with asynchronous active-low reset to zero.
module dffr #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  q <= '0;
    else if (en) q <= d;
  end
endmodule

// File: rtl/clk_div_cfg_arb.sv
// Arbitrates divider reconfiguration requests and sequences load/done/ack.
// Optional done-wait timeout with sticky err_o: define CLK_DIV_CFG_TIMEOUT_EN.
module clk_div_cfg_arb
  import clk_div_cfg_arb_pkg::*;
#(
  parameter int NUM_REQ         = DEF_NUM_REQ,
  parameter int DIV_VALUE_WIDTH = DEF_DIV_VALUE_WIDTH,
  parameter int TIMEOUT_WIDTH   = DEF_TIMEOUT_WIDTH
) (
  input  logic                                   clk_i,
  input  logic                                   rst_n_i,
  input  logic [NUM_REQ-1:0]                     req_i,
  input  logic [NUM_REQ-1:0][DIV_VALUE_WIDTH-1:0] req_div_i,
  input  logic [NUM_REQ-1:0]                     req_init_i,
  output logic [NUM_REQ-1:0]                     ack_o,
  output logic [DIV_VALUE_WIDTH-1:0]             div_o,
  output logic                                   clk_init_o,
  output logic                                   div_valid_o,
  input  logic                                   div_ready_i,
  input  logic                                   div_done_i,
`ifdef CLK_DIV_CFG_TIMEOUT_EN
  output logic                                   err_o,
`endif
  output logic                                   busy_o
);
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [1:0]         state_q;
  clk_div_cfg_state_e state, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d, grant_idx;
  logic [NUM_REQ-1:0] grant, win_q;
  logic               loaded_q;
  logic               grab, loaded_set, wait_entry, tmo_hit;

  assign state = clk_div_cfg_state_e'(state_q);

  rr_arb_ptr #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_rr (
    .req(req_i), .ptr(ptr_q), .grant(grant), .idx(grant_idx)
  );

  assign ptr_d = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + IDX_W'(1);

  always_comb begin
    state_d    = state;
    grab       = 1'b0;
    loaded_set = 1'b0;
    wait_entry = 1'b0;
    case (state)
      IDLE: if (|req_i) begin
        grab = 1'b1;
        // Same setting already in the divider: nothing to load.
        if (loaded_q && req_div_i[grant_idx] == div_o && req_init_i[grant_idx] == clk_init_o)
          state_d = ACK;
        else
          state_d = LOAD;
      end
      LOAD: if (div_ready_i) begin
        state_d    = WAIT;
        wait_entry = 1'b1;
      end
      WAIT: if (div_done_i) begin
        state_d    = ACK;
        loaded_set = 1'b1;
      end else if (tmo_hit) begin
        state_d = ACK;
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  dffr #(.W(2))               u_state  (.clk(clk_i), .rst_n(rst_n_i), .en(1'b1),       .d(state_d),               .q(state_q));
  dffr #(.W(IDX_W))           u_ptr    (.clk(clk_i), .rst_n(rst_n_i), .en(grab),       .d(ptr_d),                 .q(ptr_q));
  dffr #(.W(NUM_REQ))         u_win    (.clk(clk_i), .rst_n(rst_n_i), .en(grab),       .d(grant),                 .q(win_q));
  dffr #(.W(DIV_VALUE_WIDTH)) u_div    (.clk(clk_i), .rst_n(rst_n_i), .en(grab),       .d(req_div_i[grant_idx]),  .q(div_o));
  dffr #(.W(1))               u_init   (.clk(clk_i), .rst_n(rst_n_i), .en(grab),       .d(req_init_i[grant_idx]), .q(clk_init_o));
  dffr #(.W(1))               u_loaded (.clk(clk_i), .rst_n(rst_n_i), .en(loaded_set), .d(1'b1),                  .q(loaded_q));

`ifdef CLK_DIV_CFG_TIMEOUT_EN
  logic [TIMEOUT_WIDTH-1:0] cnt_q, cnt_inc;
  logic                     cnt_en;

  assign cnt_inc = cnt_q + TIMEOUT_WIDTH'(1);
  assign cnt_en  = wait_entry || (state == WAIT);
  assign tmo_hit = &cnt_inc;

  dffr #(.W(TIMEOUT_WIDTH)) u_cnt (.clk(clk_i), .rst_n(rst_n_i), .en(cnt_en),
                                   .d(wait_entry ? '0 : cnt_inc), .q(cnt_q));
  dffr #(.W(1)) u_err (.clk(clk_i), .rst_n(rst_n_i), .en(state == WAIT && !div_done_i && tmo_hit),
                       .d(1'b1), .q(err_o));
`else
  assign tmo_hit = 1'b0;
  // The timeout width only sizes the counter that this build leaves out.
  if (TIMEOUT_WIDTH < 1) begin : g_bad_timeout_width
  end
`endif

  assign div_valid_o = (state == LOAD);
  assign busy_o      = (state != IDLE);
  assign ack_o       = (state == ACK) ? win_q : '0;

endmodule
